// File: rtl/eth_tx_scheduler.sv
// Round-robin arbiter in front of the single Ethernet TX FSM.
// Grants one requester, latches its TX parameters and tracks busy to completion.
module eth_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   i_main_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [16*NUM_REQ-1:0]  i_req_size,
    input  logic [8*NUM_REQ-1:0]   i_req_gap,
    input  logic [NUM_REQ-1:0]     i_req_lfsr,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic [NUM_REQ-1:0]     o_done,
    output logic                   o_reject,
    output logic                   o_timeout,
    output logic [15:0]            o_tx_payload_size,
    output logic [7:0]             o_tx_gap_count,
    output logic                   o_tx_use_lfsr,
    output logic                   o_tx_start,
    input  logic                   i_tx_fsm_busy,
    output logic                   o_busy,
    output logic [31:0]            o_pkt_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, ARB, START, WAIT_BUSY, WAIT_DONE, DONE
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic [CNT_W-1:0]     to_cnt;
    logic [NUM_REQ-1:0]   req_elig;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_REQ-1:0]   win_hot;
    logic [15:0]          win_size;
    logic [7:0]           win_gap;
    logic                 win_lfsr;

    assign req_elig = i_req & ~o_done;

    // First eligible request at or after rr_ptr, wrapping to 0.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        win_hot   = '0;
        win_size  = '0;
        win_gap   = '0;
        win_lfsr  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(rr_ptr) + i) % NUM_REQ;
            if (!win_found && req_elig[j]) begin
                win_found  = 1'b1;
                win_idx    = IDX_W'(j);
                win_hot[j] = 1'b1;
                win_size   = i_req_size[16*j +: 16];
                win_gap    = i_req_gap[8*j +: 8];
                win_lfsr   = i_req_lfsr[j];
            end
        end
    end

    always_ff @(posedge i_main_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            grant_idx         <= '0;
            to_cnt            <= '0;
            o_grant           <= '0;
            o_done            <= '0;
            o_reject          <= 1'b0;
            o_timeout         <= 1'b0;
            o_tx_payload_size <= '0;
            o_tx_gap_count    <= '0;
            o_tx_use_lfsr     <= 1'b0;
            o_tx_start        <= 1'b0;
            o_busy            <= 1'b0;
            o_pkt_count       <= '0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= '0;
            o_reject   <= 1'b0;
            o_timeout  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_enable && |req_elig && !i_tx_fsm_busy) begin
                        state  <= ARB;
                        o_busy <= 1'b1;
                    end
                end
                ARB: begin
                    if (!win_found) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        o_grant           <= win_hot;
                        grant_idx         <= win_idx;
                        o_tx_payload_size <= win_size;
                        o_tx_gap_count    <= win_gap;
                        o_tx_use_lfsr     <= win_lfsr;
                        if (win_size == 16'd0) begin
                            o_reject <= 1'b1;
                            o_done   <= win_hot;
                            state    <= DONE;
                        end else begin
                            state <= START;
                        end
                    end
                end
                START: begin
                    o_tx_start <= 1'b1;
                    to_cnt     <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (i_tx_fsm_busy) begin
                        state <= WAIT_DONE;
                    end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        o_timeout <= 1'b1;
                        o_done    <= o_grant;
                        state     <= DONE;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_fsm_busy) begin
                        o_done      <= o_grant;
                        o_pkt_count <= o_pkt_count + 32'd1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                    if (grant_idx == IDX_W'(NUM_REQ - 1))
                        rr_ptr <= '0;
                    else
                        rr_ptr <= grant_idx + IDX_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler with a small TX FSM busy model.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_eth_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  req;
    logic [63:0] req_size;
    logic [31:0] req_gap;
    logic [3:0]  req_lfsr;
    logic [3:0]  grant, done;
    logic        reject, timeout;
    logic [15:0] tx_size;
    logic [7:0]  tx_gap;
    logic        tx_lfsr, tx_start, tx_busy, busy;
    logic [31:0] pkt_count;

    int errors   = 0;
    int checks   = 0;
    int exp_cnt  = 0;
    int dly      = 0;
    int rem      = 0;
    int busy_len = 5;
    bit model_en = 1'b1;

    eth_tx_scheduler #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .i_main_clk        (clk),
        .i_rst_n           (rst_n),
        .i_enable          (enable),
        .i_req             (req),
        .i_req_size        (req_size),
        .i_req_gap         (req_gap),
        .i_req_lfsr        (req_lfsr),
        .o_grant           (grant),
        .o_done            (done),
        .o_reject          (reject),
        .o_timeout         (timeout),
        .o_tx_payload_size (tx_size),
        .o_tx_gap_count    (tx_gap),
        .o_tx_use_lfsr     (tx_lfsr),
        .o_tx_start        (tx_start),
        .i_tx_fsm_busy     (tx_busy),
        .o_busy            (busy),
        .o_pkt_count       (pkt_count)
    );

    always #5 clk = ~clk;

    // TX FSM model: busy rises 3 cycles after start, stays high busy_len cycles.
    always @(posedge clk) begin
        if (model_en && tx_start) dly <= 3;
        else if (dly > 0) dly <= dly - 1;
        if (dly == 1) rem <= busy_len;
        else if (rem > 0) rem <= rem - 1;
    end
    assign tx_busy = (rem > 0);

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx_start) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done != 4'd0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_pkt(input int idx, input logic [15:0] sz);
        bit ok;
        wait_start(ok);
        chk("start_seen", 32'(ok), 32'd1);
        chk("grant", 32'(grant), 32'd1 << idx);
        chk("tx_size", 32'(tx_size), 32'(sz));
        chk("tx_gap", 32'(tx_gap), 32'(idx + 1));
        chk("tx_lfsr", 32'(tx_lfsr), 32'(idx % 2));
        wait_done(ok);
        chk("done_seen", 32'(ok), 32'd1);
        chk("done", 32'(done), 32'd1 << idx);
        exp_cnt++;
        chk("pkt_count", pkt_count, 32'(exp_cnt));
    endtask

    initial begin
        bit ok;
        int cnt;
        rst_n    = 1'b0;
        enable   = 1'b0;
        req      = 4'd0;
        req_size = 64'd0;
        req_gap  = 32'd0;
        req_lfsr = 4'd0;
        step(2);

        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'({reject, timeout, tx_start, busy, tx_lfsr}), 32'd0);
        chk("rst_tx_size", 32'(tx_size), 32'd0);
        chk("rst_tx_gap", 32'(tx_gap), 32'd0);
        chk("rst_pkt_count", pkt_count, 32'd0);
        rst_n = 1'b1;
        step(1);

        // Single requester, long busy.
        busy_len       = 150;
        enable         = 1'b1;
        req_size[15:0] = 16'd64;
        req_gap[7:0]   = 8'd12;
        req            = 4'b0001;
        step(1);
        chk("s_arb_busy", 32'(busy), 32'd1);
        chk("s_arb_grant", 32'(grant), 32'd0);
        step(1);
        chk("s_grant", 32'(grant), 32'b0001);
        chk("s_no_start_yet", 32'(tx_start), 32'd0);
        step(1);
        chk("s_start", 32'(tx_start), 32'd1);
        chk("s_size", 32'(tx_size), 32'd64);
        chk("s_gap", 32'(tx_gap), 32'd12);
        chk("s_lfsr", 32'(tx_lfsr), 32'd0);
        step(1);
        chk("s_start_pulse", 32'(tx_start), 32'd0);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (tx_busy) begin ok = 1'b1; break; end
            step(1);
        end
        chk("s_busy_rise", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            step(1);
            if (!tx_busy) begin ok = 1'b1; break; end
        end
        chk("s_busy_fall", 32'(ok), 32'd1);
        chk("s_done_not_early", 32'(done), 32'd0);
        step(1);
        chk("s_done", 32'(done), 32'b0001);
        chk("s_pkt_count", pkt_count, 32'd1);
        req = 4'd0;
        step(1);
        chk("s_grant_clear", 32'(grant), 32'd0);
        chk("s_idle", 32'(busy), 32'd0);

        // Round robin from rr_ptr = 0.
        rst_n = 1'b0;
        step(1);
        rst_n    = 1'b1;
        exp_cnt  = 0;
        busy_len = 5;
        req_size = {16'd40, 16'd30, 16'd20, 16'd10};
        req_gap  = {8'd4, 8'd3, 8'd2, 8'd1};
        req_lfsr = 4'b1010;
        req      = 4'b1111;
        run_pkt(0, 16'd10);
        run_pkt(1, 16'd20);
        run_pkt(2, 16'd30);
        run_pkt(3, 16'd40);
        run_pkt(0, 16'd10);
        run_pkt(1, 16'd20);
        req = 4'd0;
        chk("rr_count6", pkt_count, 32'd6);

        // Wrap priority: last grant 2, then 0 before 1.
        step(1);
        req = 4'b0100;
        run_pkt(2, 16'd30);
        req = 4'b0011;
        run_pkt(0, 16'd10);
        run_pkt(1, 16'd20);
        req = 4'b1000;
        run_pkt(3, 16'd40);
        req = 4'b1001;
        run_pkt(0, 16'd10);
        req = 4'd0;

        // Zero size is rejected without a start pulse.
        step(1);
        req_size[31:16] = 16'd0;
        req             = 4'b0010;
        step(1);
        chk("z_no_start_a", 32'(tx_start), 32'd0);
        step(1);
        chk("z_no_start_b", 32'(tx_start), 32'd0);
        chk("z_done", 32'(done), 32'b0010);
        chk("z_reject", 32'(reject), 32'd1);
        chk("z_pkt_count", pkt_count, 32'(exp_cnt));
        req = 4'd0;
        step(1);
        chk("z_reject_pulse", 32'(reject), 32'd0);
        chk("z_idle", 32'(busy), 32'd0);
        req_size[31:16] = 16'd20;

        // Timeout with busy never rising.
        model_en = 1'b0;
        req      = 4'b0001;
        wait_start(ok);
        chk("t_start_seen", 32'(ok), 32'd1);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step(1);
            if (done != 4'd0) cnt++;
        end
        chk("t_no_early_done", 32'(cnt), 32'd0);
        step(1);
        chk("t_done", 32'(done), 32'b0001);
        chk("t_timeout", 32'(timeout), 32'd1);
        chk("t_pkt_count", pkt_count, 32'(exp_cnt));
        req      = 4'd0;
        model_en = 1'b1;
        step(1);
        req = 4'b0010;
        run_pkt(1, 16'd20);
        req = 4'd0;

        // Enable gating.
        step(1);
        enable = 1'b0;
        req    = 4'b0001;
        cnt    = 0;
        for (int k = 0; k < 100; k++) begin
            step(1);
            if (grant != 4'd0 || busy) cnt++;
        end
        chk("e_no_grant", 32'(cnt), 32'd0);
        busy_len = 30;
        enable   = 1'b1;
        step(2);
        chk("e_grant", 32'(grant), 32'b0001);

        // Reset while waiting for the TX FSM to finish.
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (tx_busy) begin ok = 1'b1; break; end
        end
        chk("r_busy_rise", 32'(ok), 32'd1);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("r_grant", 32'(grant), 32'd0);
        chk("r_flags", 32'({done, reject, timeout, tx_start, busy}), 32'd0);
        chk("r_tx_regs", 32'({tx_size, tx_gap, tx_lfsr}), 32'd0);
        chk("r_pkt_count", pkt_count, 32'd0);
        req = 4'd0;
        step(2);
        rst_n   = 1'b1;
        exp_cnt = 0;
        ok      = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step(1);
            if (!tx_busy) begin ok = 1'b1; break; end
        end
        chk("r_busy_fall", 32'(ok), 32'd1);
        busy_len = 5;
        req      = 4'b0101;
        run_pkt(0, 16'd10);
        req = 4'd0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
